// File: rtl/sb_rr_arbiter.sv
// rtl/sb_rr_arbiter.sv - packet-aware round-robin merge of N switchboard streams
//
// Merges N data/dest/last streams into one registered output stream. The grant
// is held from the first flit of a packet until its last flit is accepted, so
// packets never interleave. Priority rotates to the input after the one that
// just finished a packet.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_data         N*DW   input data, stream i at [i*DW +: DW]
//   in_dest         N*32   input destination, stream i at [i*32 +: 32]
//   in_last         N      end-of-packet per stream
//   in_valid        N      flit present per stream
//   in_ready        N      per-stream accept (combinational)
//   out_data/dest/last/valid   registered output flit
//   out_ready       consumer accept
//   out_src         index of the input that supplied the current output flit
module sb_rr_arbiter #(
    parameter int N  = 2,
    parameter int DW = 416,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*DW-1:0] in_data,
    input  logic [N*32-1:0] in_dest,
    input  logic [N-1:0]    in_last,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [DW-1:0]   out_data,
    output logic [31:0]     out_dest,
    output logic            out_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_src
);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_ptr;
    logic [SW-1:0]   r_lock_id;
    logic [DW-1:0]   r_out_data;
    logic [31:0]     r_out_dest;
    logic            r_out_last;
    logic            r_out_valid;
    logic [SW-1:0]   r_out_src;

    logic            w_load;
    logic            w_have;
    logic            w_xfer;
    logic [SW-1:0]   w_sel;
    logic [SW-1:0]   w_ptr_nxt;
    int              w_idx;

    // The output register can take a flit when empty or being drained.
    assign w_load = !r_out_valid || out_ready;

    // Pick the input to serve. While locked the owner keeps the grant even if
    // it drops valid; otherwise scan from ptr upward with wrap. The scan runs
    // from lowest to highest priority so the last hit is the winner.
    always_comb begin
        w_sel  = r_lock_id;
        w_have = 1'b0;
        w_idx  = 0;
        if (r_state == S_LOCKED) begin
            w_sel  = r_lock_id;
            w_have = 1'b1;
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                w_idx = (int'(r_ptr) + i) % N;
                if (in_valid[w_idx]) begin
                    w_sel  = SW'(w_idx);
                    w_have = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (w_have && w_load && !rst) begin
            in_ready[w_sel] = 1'b1;
        end
    end

    assign w_xfer    = w_have && w_load && in_valid[w_sel] && !rst;
    assign w_ptr_nxt = (w_sel == SW'(N - 1)) ? '0 : w_sel + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_lock_id   <= '0;
            r_out_data  <= '0;
            r_out_dest  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
        end else if (w_xfer) begin
            r_out_data  <= in_data[w_sel*DW +: DW];
            r_out_dest  <= in_dest[w_sel*32 +: 32];
            r_out_last  <= in_last[w_sel];
            r_out_valid <= 1'b1;
            r_out_src   <= w_sel;
            if (in_last[w_sel]) begin
                // Priority rotates only at packet boundaries.
                r_state <= S_IDLE;
                r_ptr   <= w_ptr_nxt;
            end else begin
                r_state   <= S_LOCKED;
                r_lock_id <= w_sel;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_dest  = r_out_dest;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_sb_rr_arbiter.sv
// tb/tb_sb_rr_arbiter.sv - directed self-checking bench for sb_rr_arbiter
module tb_sb_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance A: N=2
    logic [31:0]  a_in_data;
    logic [63:0]  a_in_dest;
    logic [1:0]   a_in_last;
    logic [1:0]   a_in_valid;
    logic [1:0]   a_in_ready;
    logic [15:0]  a_out_data;
    logic [31:0]  a_out_dest;
    logic         a_out_last;
    logic         a_out_valid;
    logic         a_out_ready;
    logic [0:0]   a_out_src;

    // Instance B: N=4
    logic [63:0]  b_in_data;
    logic [127:0] b_in_dest;
    logic [3:0]   b_in_last;
    logic [3:0]   b_in_valid;
    logic [3:0]   b_in_ready;
    logic [15:0]  b_out_data;
    logic [31:0]  b_out_dest;
    logic         b_out_last;
    logic         b_out_valid;
    logic         b_out_ready;
    logic [1:0]   b_out_src;

    int n_checks = 0;
    int n_fail   = 0;

    sb_rr_arbiter #(.N(2), .DW(16)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (a_in_data),
        .in_dest   (a_in_dest),
        .in_last   (a_in_last),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_dest  (a_out_dest),
        .out_last  (a_out_last),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_src   (a_out_src)
    );

    sb_rr_arbiter #(.N(4), .DW(16)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (b_in_data),
        .in_dest   (b_in_dest),
        .in_last   (b_in_last),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_dest  (b_out_dest),
        .out_last  (b_out_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_src   (b_out_src)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_d;
        a_in_data = '0; a_in_dest = '0; a_in_last = '0; a_in_valid = '0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_dest = '0; b_in_last = '0; b_in_valid = '0; b_out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- reset asserted mid-cycle ----------------
        a_in_valid = 2'b11;
        a_in_last  = 2'b11;
        a_in_data  = {16'h00B1, 16'h00A0};
        a_in_dest  = {32'h000000D1, 32'h000000D0};
        rst = 1'b0;
        tick();
        chk("pre_rst_valid", a_out_valid, 1);
        #4;
        rst = 1'b1;
        #1;
        chk("rst_valid", a_out_valid, 0);
        chk("rst_data", a_out_data, 0);
        chk("rst_dest", a_out_dest, 0);
        chk("rst_last", a_out_last, 0);
        chk("rst_src", a_out_src, 0);
        chk("rst_ready", a_in_ready, 2'b00);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", a_in_ready, 2'b01);

        // ---------------- fairness: alternating single-flit packets ----------------
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("fair_src", a_out_src, k % 2);
            chk("fair_data", a_out_data, (k % 2) ? 16'h00B1 : 16'h00A0);
            chk("fair_dest", a_out_dest, (k % 2) ? 32'hD1 : 32'hD0);
            chk("fair_valid", a_out_valid, 1);
            chk("fair_ready", a_in_ready, (k % 2) ? 2'b01 : 2'b10);
        end

        // ---------------- packet lock: 3-flit packet from input 0 ----------------
        a_in_last        = 2'b10;
        a_in_data[15:0]  = 16'h00C1;
        #1;
        chk("lock_ready0", a_in_ready, 2'b01);
        tick();
        chk("lock1_src", a_out_src, 0);
        chk("lock1_data", a_out_data, 16'h00C1);
        chk("lock1_last", a_out_last, 0);
        chk("lock1_ready", a_in_ready, 2'b01);
        a_in_data[15:0] = 16'h00C2;
        tick();
        chk("lock2_src", a_out_src, 0);
        chk("lock2_data", a_out_data, 16'h00C2);
        chk("lock2_ready", a_in_ready, 2'b01);
        a_in_last       = 2'b11;
        a_in_data[15:0] = 16'h00C3;
        tick();
        chk("lock3_src", a_out_src, 0);
        chk("lock3_data", a_out_data, 16'h00C3);
        chk("lock3_last", a_out_last, 1);
        chk("lock3_ready", a_in_ready, 2'b10);
        tick();
        chk("lock4_src", a_out_src, 1);
        chk("lock4_data", a_out_data, 16'h00B1);

        // ---------------- backpressure ----------------
        a_out_ready = 1'b0;
        #1;
        chk("bp_ready0", a_in_ready, 2'b00);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_data", a_out_data, 16'h00B1);
            chk("bp_dest", a_out_dest, 32'hD1);
            chk("bp_src", a_out_src, 1);
            chk("bp_valid", a_out_valid, 1);
            chk("bp_ready", a_in_ready, 2'b00);
        end
        for (int k = 0; k < 4; k++) begin
            a_in_data[15:0]  = 16'h0D00 + 16'(k);
            a_in_data[31:16] = 16'h0E00 + 16'(k);
            a_in_dest[31:0]  = 32'h100 + 32'(k);
            a_in_dest[63:32] = 32'h200 + 32'(k);
            a_out_ready = 1'b1;
            tick();
            exp_d = (k % 2) ? 16'h0E00 + 16'(k) : 16'h0D00 + 16'(k);
            chk("rel_src", a_out_src, k % 2);
            chk("rel_data", a_out_data, exp_d);
            chk("rel_dest", a_out_dest, (k % 2) ? 32'h200 + 32'(k) : 32'h100 + 32'(k));
            chk("rel_valid", a_out_valid, 1);
        end
        a_in_valid = 2'b00;

        // ---------------- N=4: wrap from ptr=3 ----------------
        b_in_last          = 4'b1111;
        b_in_valid         = 4'b0100;
        b_in_data[47:32]   = 16'h0020;
        b_in_dest[95:64]   = 32'h2;
        #1;
        chk("b_grant2_ready", b_in_ready, 4'b0100);
        tick();
        chk("b_grant2_src", b_out_src, 2);
        chk("b_grant2_data", b_out_data, 16'h0020);
        b_in_valid       = 4'b1001;
        b_in_data[15:0]  = 16'h0010;
        b_in_data[63:48] = 16'h0030;
        #1;
        chk("b_wrap_ready", b_in_ready, 4'b1000);
        tick();
        chk("b_wrap_src3", b_out_src, 3);
        chk("b_wrap_data3", b_out_data, 16'h0030);
        chk("b_wrap_ready0", b_in_ready, 4'b0001);
        b_in_last = 4'b1110;
        tick();
        chk("b_wrap_src0", b_out_src, 0);
        chk("b_wrap_data0", b_out_data, 16'h0010);
        chk("b_wrap_last0", b_out_last, 0);

        // ---------------- stall: locked input drops valid ----------------
        b_in_valid = 4'b1110;
        #1;
        chk("b_stall_ready0", b_in_ready, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("b_stall_valid", b_out_valid, 0);
            chk("b_stall_ready", b_in_ready, 4'b0001);
        end
        b_in_valid      = 4'b1111;
        b_in_last       = 4'b1111;
        b_in_data[15:0] = 16'h0011;
        tick();
        chk("b_resume_src", b_out_src, 0);
        chk("b_resume_data", b_out_data, 16'h0011);
        chk("b_resume_last", b_out_last, 1);
        chk("b_resume_valid", b_out_valid, 1);

        // ---------------- reset during LOCKED(2) ----------------
        b_in_valid       = 4'b0100;
        b_in_last        = 4'b1011;
        b_in_data[47:32] = 16'h0021;
        b_in_data[31:16] = 16'h0041;
        #1;
        chk("b_l2_ready", b_in_ready, 4'b0100);
        tick();
        chk("b_l2_src", b_out_src, 2);
        chk("b_l2_last", b_out_last, 0);
        b_in_valid = 4'b0110;
        #1;
        chk("b_l2_hold_ready", b_in_ready, 4'b0100);
        #3;
        rst = 1'b1;
        #1;
        chk("b_rst_valid", b_out_valid, 0);
        chk("b_rst_src", b_out_src, 0);
        chk("b_rst_ready", b_in_ready, 4'b0000);
        rst = 1'b0;
        #1;
        chk("b_post_rst_ready", b_in_ready, 4'b0010);
        tick();
        chk("b_post_rst_src", b_out_src, 1);
        chk("b_post_rst_data", b_out_data, 16'h0041);
        chk("b_post_rst_valid", b_out_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sb_rr_arbiter.md
# sb_rr_arbiter

Packet-aware round-robin arbiter that merges N switchboard-style streams (data/dest/last with valid/ready) into one output stream. It sits between several packet sources, such as queue-to-switchboard receivers, and a single shared consumer. The grant is locked from the first flit of a packet until its `last` flit is accepted, so packets are never interleaved. The output is registered and sustains one flit per cycle.

## Interface
Parameters:
- `N`, 2: number of input streams, ≥1.
- `DW`, 416: data width in bits.
- `SW`, derived as (N>1 ? $clog2(N) : 1): source-index width. Not user-set.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_data`  in  N*DW  input data; stream i occupies bits [i*DW +: DW].
- `in_dest`  in  N*32  input destination; stream i occupies bits [i*32 +: 32].
- `in_last`  in  N  end-of-packet flag per stream.
- `in_valid`  in  N  flit-present flag per stream.
- `in_ready`  out  N  per-stream accept (combinational).
- `out_data`  out  DW  registered output data.
- `out_dest`  out  32  registered output destination.
- `out_last`  out  1  registered end-of-packet flag.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  consumer accept.
- `out_src`  out  SW  index of the input that supplied the current output flit.

## Operation
- A transfer occurs on any interface when valid and ready are both high at a rising edge.
- `load = !out_valid || out_ready`. The output register can take a new flit this cycle.
- States:
  - IDLE: no packet in progress.
  - LOCKED(lock_id): a packet from `lock_id` is mid-flight.
- Round-robin pointer `ptr` (SW bits) names the highest-priority input.
- In IDLE:
  - `g` is the first i with `in_valid[i]=1`, searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - `in_ready[g] = load`. All other `in_ready` bits are 0.
  - If no input is valid, all `in_ready` bits are 0.
- In LOCKED: `in_ready[lock_id] = load`. All other `in_ready` bits are 0, regardless of their valid.
- `in_ready` may depend combinationally on `in_valid` and `out_ready`. Upstream must not make valid depend on ready.
- On an input transfer from stream s:
  - `out_data`, `out_dest`, `out_last` take s's fields; `out_src <= s`; `out_valid <= 1`.
  - If `in_last[s]=0`: state becomes LOCKED(s).
  - If `in_last[s]=1`: state becomes IDLE and `ptr <= (s+1) mod N`, wrapping N-1 to 0.
- When `out_ready=1` and `out_valid=1` with no input transfer that cycle: `out_valid <= 0`. Data fields hold their values.
- `ptr` advances only at packet end, never on the mid-packet flits of a multi-flit packet.
- If the locked input drops `in_valid` mid-packet, the arbiter waits indefinitely. There is no timeout and no other input is served.
- N=1: `ptr` and `out_src` are constantly 0, and the block behaves as a registered pipeline stage.

## Timing
- Reset values (while `rst` is high, and immediately when it asserts):
  - `out_valid=0`, `out_data=0`, `out_dest=0`, `out_last=0`, `out_src=0`.
  - state IDLE, `ptr=0`.
  - `in_ready` forced to all 0.
- Reset mid-packet: the lock and the buffered flit are discarded. After reset the arbiter is in IDLE; recovering the partial packet is the upstream's responsibility.
- Latency: an input flit accepted at edge k appears on the output in the cycle after edge k.
- Throughput: one flit per cycle when `out_ready` is held at 1.
- Back-to-back single-flit packets from different inputs: the grant may switch on consecutive cycles with no bubble.
- `out_ready=0` while `out_valid=1`: all output fields stay stable and all `in_ready` bits are 0.
- Simultaneous output drain and input accept in one cycle: the new flit overwrites the register and `out_valid` stays 1.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle with `in_valid=2'b11` → all outputs 0 and `in_ready=0` at once; after release, first grant goes to input 0.
- Fairness, N=2: both inputs stream 1-flit packets with `out_ready=1` → `out_src` sequence 0,1,0,1,… and `in_ready` alternates `01`,`10`.
- Packet lock: input 0 sends a 3-flit packet (last on flit 3) while input 1 is continuously valid → `out_src` reads 0,0,0,1 and `in_ready[1]=0` for the first three cycles.
- Backpressure: hold `out_ready=0` for 4 cycles with output valid → output fields are unchanged and `in_ready=0`; release gives one transfer per cycle, with no flits lost or duplicated (scoreboard data/dest/last).
- Wrap and stall, N=4 with `ptr=3`: inputs 0 and 3 valid → grant 3, then 0. Then drop `in_valid` on the locked input mid-packet for 5 cycles → `out_valid` goes 0 after the drain, no other input is granted, and the packet resumes from the same source.
- Reset mid-packet: assert `rst` during LOCKED(2) → after release the state is IDLE with `ptr=0`, and a valid input 1 is granted.
